// File: rtl/oam_dma.sv
// Sprite OAM DMA engine: a CPU write to the trigger address stalls the CPU and
// copies one 256-byte page into PPU OAMDATA as parity-aligned READ/WRITE pairs.
module oam_dma #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [15:0] OAMDATA_ADDR = 16'h2004
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [15:0] i_address,
  input  logic        i_rw,
  input  logic [7:0]  i_data,
  output logic        o_rdy,
  output logic        o_bus_master,
  output logic [15:0] o_address,
  output logic [7:0]  o_data,
  output logic        o_rw
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] page_q, page_d;
  logic [DW-1:0] index_q, index_d;
  logic [DW-1:0] latch_q, latch_d;
  logic          odd_q, odd_d;

  logic          rdy_q, rdy_d;
  logic          bus_master_q, bus_master_d;
  logic [AW-1:0] address_q, address_d;
  logic [DW-1:0] data_q, data_d;
  logic          rw_q, rw_d;

  logic          trigger_c;

  assign trigger_c = (i_address == TRIGGER_ADDR) && !i_rw;

  // State and datapath registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      page_q  <= '0;
      index_q <= '0;
      latch_q <= '0;
      odd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      index_q <= index_d;
      latch_q <= latch_d;
      odd_q   <= odd_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    index_d = index_q;
    latch_d = latch_q;
    odd_d   = ~odd_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger_c) begin
          page_d  = i_data;
          index_d = '0;
          state_d = ST_HALT;
        end
      end
      // An odd HALT means the next cycle is even, so the READ can start at once
      ST_HALT:  state_d = odd_q ? ST_READ : ST_ALIGN;
      ST_ALIGN: state_d = ST_READ;
      ST_READ: begin
        latch_d = i_data;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (index_q == 8'hFF) begin
          state_d = ST_IDLE;
        end else begin
          index_d = index_q + DW'(1);
          state_d = ST_READ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming registered state, so outputs are pure flops
  always_comb begin
    rdy_d        = 1'b1;
    bus_master_d = 1'b0;
    address_d    = '0;
    data_d       = '0;
    rw_d         = 1'b1;
    case (state_d)
      ST_HALT, ST_ALIGN: begin
        rdy_d        = 1'b0;
        bus_master_d = 1'b1;
      end
      ST_READ: begin
        rdy_d        = 1'b0;
        bus_master_d = 1'b1;
        address_d    = {page_d, index_d};
      end
      ST_WRITE: begin
        rdy_d        = 1'b0;
        bus_master_d = 1'b1;
        address_d    = OAMDATA_ADDR;
        data_d       = latch_d;
        rw_d         = 1'b0;
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rdy_q        <= 1'b1;
      bus_master_q <= 1'b0;
      address_q    <= '0;
      data_q       <= '0;
      rw_q         <= 1'b1;
    end else begin
      rdy_q        <= rdy_d;
      bus_master_q <= bus_master_d;
      address_q    <= address_d;
      data_q       <= data_d;
      rw_q         <= rw_d;
    end
  end

  assign o_rdy        = rdy_q;
  assign o_bus_master = bus_master_q;
  assign o_address    = address_q;
  assign o_data       = data_q;
  assign o_rw         = rw_q;

endmodule
